// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage datapath owning the 16-bit data memory and the stack pointer.
//   Splits 32-bit transfers into two 16-bit accesses, stalling upstream for one cycle.
//   Optional build macro STACK_GUARD_EN: suppresses out-of-bounds stack ops and raises o_stack_err.
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-low reset
//   i_valid          memory op present
//   i_mem_read/write load/store (pop/push with i_is_stack); write wins when both are high
//   i_is_stack       address comes from the stack pointer
//   i_en32           32-bit transfer
//   i_addr, i_wdata  ALU address (low ADDR_W bits) and store data
//   o_stall          hold upstream buffer (first cycle of an accepted 32-bit op)
//   o_done           one-cycle completion pulse
//   o_rdata          registered load/pop data
//   o_sp             current stack pointer
//   o_stack_err      sticky stack bounds error
module mem_access_unit #(
  parameter int ADDR_W = 11,
  parameter int SP_INIT = 2047
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic              i_is_stack,
  input  logic              i_en32,
  input  logic [15:0]       i_addr,
  input  logic [31:0]       i_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [31:0]       o_rdata,
  output logic [ADDR_W-1:0] o_sp,
  output logic              o_stack_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic IDLE = 1'b0;
  localparam logic HALF2 = 1'b1;
  localparam logic [ADDR_W-1:0] SP0 = ADDR_W'(SP_INIT);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  logic              state;
  logic [ADDR_W-1:0] sp;
  logic              h_write, h_stack;
  logic [ADDR_W-1:0] h_addr;
  logic [15:0]       h_data, lo_buf;
  logic [15:0]       mem [DEPTH];
  logic              h2, acc, wr, stk, viol, go, split;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       wd, rword;
`ifdef STACK_GUARD_EN
  logic [ADDR_W-1:0] depth;
`endif
  assign o_sp = sp;
  always_comb begin
    h2 = state == HALF2;
    acc = rst & ~h2 & i_valid & (i_mem_read | i_mem_write);
    wr = h2 ? h_write : i_mem_write;
    stk = h2 ? h_stack : i_is_stack;
`ifdef STACK_GUARD_EN
    depth = SP0 - sp;
    viol = acc & i_is_stack & (i_mem_write ? (sp == '0 || (i_en32 && sp == ONE))
                                           : (depth == '0 || (i_en32 && depth == ONE)));
`else
    viol = 1'b0;
`endif
    go = h2 | (acc & ~viol);
    split = acc & ~viol & i_en32;
    // In HALF2 the stack pointer has already moved one word, so the stack address
    // of the second word follows from the same rule as the first.
    addr = (h2 & ~h_stack) ? h_addr : stk ? (wr ? sp : sp + ONE) : i_addr[ADDR_W-1:0];
    // Pushes write the high word first (at the higher address); everything else low first.
    wd = h2 ? h_data : (i_is_stack & i_en32) ? i_wdata[31:16] : i_wdata[15:0];
    rword = mem[addr];
    o_stall = split;
  end
  always_ff @(posedge clk)
    if (go & wr) mem[addr] <= wd;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sp <= SP0;
      o_done <= 1'b0;
      o_rdata <= '0;
      o_stack_err <= 1'b0;
      h_write <= 1'b0;
      h_stack <= 1'b0;
      h_addr <= '0;
      h_data <= '0;
      lo_buf <= '0;
    end else begin
      state <= split ? HALF2 : IDLE;
      o_done <= h2 | (acc & (~i_en32 | viol));
      if (go & stk) sp <= wr ? sp - ONE : sp + ONE;
      if (split) begin
        h_write <= i_mem_write;
        h_stack <= i_is_stack;
        h_addr <= i_addr[ADDR_W-1:0] + ONE;
        h_data <= i_is_stack ? i_wdata[15:0] : i_wdata[31:16];
      end
      // o_rdata only changes when a load completes; the first half of a 32-bit load parks in lo_buf.
      if (go & ~wr) begin
        if (h2) o_rdata <= {rword, lo_buf};
        else if (i_en32) lo_buf <= rword;
        else o_rdata <= {16'h0, rword};
      end
      if (viol) o_stack_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed self-checking bench for mem_access_unit
module tb_mem_access_unit;
  logic clk = 0, rst = 0;
  logic i_valid = 0, i_mem_read = 0, i_mem_write = 0, i_is_stack = 0, i_en32 = 0;
  logic [15:0] i_addr = 0;
  logic [31:0] i_wdata = 0;
  logic o_stall, o_done, o_stack_err;
  logic [31:0] o_rdata;
  logic [10:0] o_sp;
  int checks = 0, errors = 0;
  logic [15:0] m [2048];
  int msp = 2047;
  logic [31:0] mrd = 0;
  logic merr = 0;

  mem_access_unit dut (.clk(clk), .rst(rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_is_stack(i_is_stack), .i_en32(i_en32), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_stall(o_stall), .o_done(o_done), .o_rdata(o_rdata), .o_sp(o_sp),
    .o_stack_err(o_stack_err));

  always #5 clk = ~clk;

  // Reference model: applies one op to a word-array view of memory and the stack.
  task automatic model_op(input logic w, r, s, e, input logic [15:0] a, input logic [31:0] d,
                          output int ecyc, output int est);
    int n, ad;
    ecyc = 4; est = 0;
    if (!(w || r)) return;
    n = e ? 2 : 1;
    ecyc = n; est = n - 1;
    if (s) begin
`ifdef STACK_GUARD_EN
      if (w ? (msp < n) : (2047 - msp < n)) begin merr = 1; ecyc = 1; est = 0; return; end
`endif
      if (w) begin
        if (e) begin m[msp] = d[31:16]; m[(msp - 1) & 2047] = d[15:0]; end
        else m[msp] = d[15:0];
        msp = (msp - n) & 2047;
      end else begin
        mrd = e ? {m[(msp + 2) & 2047], m[(msp + 1) & 2047]} : {16'h0, m[(msp + 1) & 2047]};
        msp = (msp + n) & 2047;
      end
    end else begin
      ad = int'(a) & 2047;
      if (w) begin m[ad] = d[15:0]; if (e) m[(ad + 1) & 2047] = d[31:16]; end
      else mrd = e ? {m[(ad + 1) & 2047], m[ad]} : {16'h0, m[ad]};
    end
  endtask

  // Presents one op and holds it until o_done or a 4-cycle budget expires.
  task automatic run_op(input logic w, r, s, e, input logic [15:0] a, input logic [31:0] d,
                        output int cyc, output int stalls);
    @(negedge clk);
    i_valid = 1; i_mem_write = w; i_mem_read = r; i_is_stack = s; i_en32 = e; i_addr = a; i_wdata = d;
    cyc = 0; stalls = 0;
    do begin
      #1;
      if (o_stall) stalls++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end while (!o_done && cyc < 4);
    i_valid = 0; i_mem_write = 0; i_mem_read = 0;
  endtask

  task automatic op(input logic w, r, s, e, input logic [15:0] a, input logic [31:0] d,
                    output int cyc, output int stalls, output int ecyc, output int est);
    model_op(w, r, s, e, a, d, ecyc, est);
    run_op(w, r, s, e, a, d, cyc, stalls);
  endtask

  task automatic test_reset;
    rst = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    msp = 2047; mrd = 0; merr = 0;
    @(negedge clk);
    checks += 5;
    if (o_sp !== 11'd2047) begin errors++; $display("FAIL reset_sp got %0d want 2047", o_sp); end
    if (o_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", o_rdata); end
    if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
    if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", o_stall); end
    if (o_stack_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_stack_err); end
  endtask

  task automatic test_store_load16;
    int c, s, ec, es;
    op(1, 0, 0, 0, 16'h0010, 32'h000000AB, c, s, ec, es);
    checks += 3;
    if (c != 1) begin errors++; $display("FAIL st16_latency got %0d want 1", c); end
    if (s != 0) begin errors++; $display("FAIL st16_stall got %0d want 0", s); end
    if (o_rdata !== 32'h0) begin errors++; $display("FAIL st16_rdata_hold got %h want 0", o_rdata); end
    op(0, 1, 0, 0, 16'h0010, 32'h0, c, s, ec, es);
    checks += 3;
    if (c != 1) begin errors++; $display("FAIL ld16_latency got %0d want 1", c); end
    if (s != 0) begin errors++; $display("FAIL ld16_stall got %0d want 0", s); end
    if (o_rdata !== 32'h000000AB) begin errors++; $display("FAIL ld16_rdata got %h want 000000ab", o_rdata); end
  endtask

  task automatic test_store_load32;
    int c, s, ec, es;
    op(1, 0, 0, 1, 16'h0020, 32'h12345678, c, s, ec, es);
    checks += 3;
    if (c != 2) begin errors++; $display("FAIL st32_latency got %0d want 2", c); end
    if (s != 1) begin errors++; $display("FAIL st32_stall got %0d want 1", s); end
    if (o_rdata !== 32'h000000AB) begin errors++; $display("FAIL st32_rdata_hold got %h want 000000ab", o_rdata); end
    op(0, 1, 0, 0, 16'h0020, 32'h0, c, s, ec, es);
    checks++;
    if (o_rdata !== 32'h00005678) begin errors++; $display("FAIL st32_low_word got %h want 00005678", o_rdata); end
    op(0, 1, 0, 0, 16'h0021, 32'h0, c, s, ec, es);
    checks++;
    if (o_rdata !== 32'h00001234) begin errors++; $display("FAIL st32_high_word got %h want 00001234", o_rdata); end
    op(0, 1, 0, 1, 16'h0020, 32'h0, c, s, ec, es);
    checks += 3;
    if (c != 2) begin errors++; $display("FAIL ld32_latency got %0d want 2", c); end
    if (s != 1) begin errors++; $display("FAIL ld32_stall got %0d want 1", s); end
    if (o_rdata !== 32'h12345678) begin errors++; $display("FAIL ld32_rdata got %h want 12345678", o_rdata); end
  endtask

  task automatic test_stack;
    int c, s, ec, es;
    op(1, 0, 1, 1, 16'h0, 32'hCAFEBABE, c, s, ec, es);
    checks += 2;
    if (o_sp !== 11'd2045) begin errors++; $display("FAIL push32_sp got %0d want 2045", o_sp); end
    if (c != 2 || s != 1) begin errors++; $display("FAIL push32_timing got %0d/%0d want 2/1", c, s); end
    op(0, 1, 0, 0, 16'd2047, 32'h0, c, s, ec, es);
    checks++;
    if (o_rdata !== 32'h0000CAFE) begin errors++; $display("FAIL push32_mem2047 got %h want 0000cafe", o_rdata); end
    op(0, 1, 0, 0, 16'd2046, 32'h0, c, s, ec, es);
    checks++;
    if (o_rdata !== 32'h0000BABE) begin errors++; $display("FAIL push32_mem2046 got %h want 0000babe", o_rdata); end
    op(0, 1, 1, 1, 16'h0, 32'h0, c, s, ec, es);
    checks += 2;
    if (o_rdata !== 32'hCAFEBABE) begin errors++; $display("FAIL pop32_rdata got %h want cafebabe", o_rdata); end
    if (o_sp !== 11'd2047) begin errors++; $display("FAIL pop32_sp got %0d want 2047", o_sp); end
    op(1, 0, 1, 0, 16'h0, 32'h00000042, c, s, ec, es);
    checks++;
    if (o_sp !== 11'd2046) begin errors++; $display("FAIL push16_sp got %0d want 2046", o_sp); end
    op(0, 1, 1, 0, 16'h0, 32'h0, c, s, ec, es);
    checks += 2;
    if (o_rdata !== 32'h00000042) begin errors++; $display("FAIL pop16_rdata got %h want 00000042", o_rdata); end
    if (o_sp !== 11'd2047) begin errors++; $display("FAIL pop16_sp got %0d want 2047", o_sp); end
  endtask

  task automatic test_reset_half2;
    int c, s, ec, es, done_seen;
    op(1, 0, 0, 0, 16'h0031, 32'h00001111, c, s, ec, es);
    @(negedge clk);
    i_valid = 1; i_mem_write = 1; i_mem_read = 0; i_is_stack = 0; i_en32 = 1;
    i_addr = 16'h0030; i_wdata = 32'hAAAA5555;
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    checks++;
    if (o_stall !== 1'b0) begin errors++; $display("FAIL half2_reset_stall got %b want 0", o_stall); end
    m[16'h30] = 16'h5555; msp = 2047; mrd = 0;
    done_seen = 0;
    @(negedge clk);
    i_valid = 0; i_mem_write = 0; i_en32 = 0;
    rst = 1;
    repeat (3) begin @(negedge clk); if (o_done) done_seen++; end
    checks += 3;
    if (done_seen != 0) begin errors++; $display("FAIL half2_reset_done got %0d want 0", done_seen); end
    if (o_sp !== 11'd2047) begin errors++; $display("FAIL half2_reset_sp got %0d want 2047", o_sp); end
    if (o_rdata !== 32'h0) begin errors++; $display("FAIL half2_reset_rdata got %h want 0", o_rdata); end
    op(0, 1, 0, 0, 16'h0031, 32'h0, c, s, ec, es);
    checks++;
    if (o_rdata !== 32'h00001111) begin errors++; $display("FAIL half2_reset_mem31 got %h want 00001111", o_rdata); end
    op(0, 1, 0, 0, 16'h0030, 32'h0, c, s, ec, es);
    checks++;
    if (o_rdata !== 32'h00005555) begin errors++; $display("FAIL half2_reset_mem30 got %h want 00005555", o_rdata); end
  endtask

  task automatic test_guard;
    int c, s, ec, es;
    logic [31:0] prev;
    op(1, 0, 0, 0, 16'h0000, 32'h00000BEE, c, s, ec, es);
    op(0, 1, 0, 0, 16'h0031, 32'h0, c, s, ec, es);
    prev = o_rdata;
    op(0, 1, 1, 0, 16'h0, 32'h0, c, s, ec, es);
    checks += 4;
    if (c != 1) begin errors++; $display("FAIL guard_done got %0d want 1", c); end
`ifdef STACK_GUARD_EN
    if (o_stack_err !== 1'b1) begin errors++; $display("FAIL guard_err got %b want 1", o_stack_err); end
    if (o_sp !== 11'd2047) begin errors++; $display("FAIL guard_sp got %0d want 2047", o_sp); end
    if (o_rdata !== prev) begin errors++; $display("FAIL guard_rdata got %h want %h", o_rdata, prev); end
`else
    if (o_stack_err !== 1'b0) begin errors++; $display("FAIL guard_err got %b want 0", o_stack_err); end
    if (o_sp !== 11'd0) begin errors++; $display("FAIL guard_sp got %0d want 0", o_sp); end
    if (o_rdata !== 32'h00000BEE) begin errors++; $display("FAIL guard_rdata got %h want 00000bee (prev %h)", o_rdata, prev); end
`endif
  endtask

  task automatic test_random;
    int c, s, ec, es, kind, depth;
    logic w, r, st, e;
    logic [15:0] a;
    for (int i = 0; i < 16; i++) op(1, 0, 0, 0, 16'h0100 + 16'(i), $urandom, c, s, ec, es);
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 5);
      depth = 2047 - msp;
      e = 1'($urandom);
      st = 0; w = 0; r = 0;
      a = 16'h0100 + 16'($urandom_range(0, 14)) + {5'($urandom), 11'h0};
      case (kind)
        0, 1: begin w = 1'($urandom); r = ~w; end
        2: begin st = 1; if (depth < 20) w = 1; else r = 1; end
        3: begin st = 1; if (depth >= (e ? 2 : 1)) r = 1; else w = 1; end
        4: begin w = 1; r = 1; end
        default: st = 1'($urandom);
      endcase
      op(w, r, st, e, a, $urandom, c, s, ec, es);
      checks += 5;
      if (c != ec) begin errors++; $display("FAIL rnd%0d_latency got %0d want %0d", i, c, ec); end
      if (s != es) begin errors++; $display("FAIL rnd%0d_stall got %0d want %0d", i, s, es); end
      if (o_rdata !== mrd) begin errors++; $display("FAIL rnd%0d_rdata got %h want %h", i, o_rdata, mrd); end
      if (o_sp !== 11'(msp)) begin errors++; $display("FAIL rnd%0d_sp got %0d want %0d", i, o_sp, msp); end
      if (o_stack_err !== merr) begin errors++; $display("FAIL rnd%0d_err got %b want %b", i, o_stack_err, merr); end
    end
  endtask

  initial begin
    test_reset;
    test_store_load16;
    test_store_load32;
    test_stack;
    test_reset_half2;
    test_guard;
    test_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
